// File: rtl/uart_transmitter.sv
// UART 16750 transmit serializer: frames one character as start, 5-8 data bits LSB first,
// optional parity and 1/1.5/2 stop bits. Bit timing comes from a x16 baud enable.
module uart_transmitter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TXCLK,
    input  logic       TXSTART,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic [7:0] DIN,
    output logic       TXFINISHED,
    output logic       SOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_STOP2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] wls_q, wls_d;
    logic       stb_q, stb_d;
    logic       pen_q, pen_d;
    logic       par_q, par_d;
    logic       sout_q, sout_d;
    logic       txfinished_q, txfinished_d;

    logic       level;
    logic       bit_end;
    logic       frame_done;
    logic [7:0] din_mask;
    logic       din_xor;

    // Parity is resolved once at latch time from only the bits that will be sent.
    assign din_mask = 8'hFF >> (2'd3 - WLS);
    assign din_xor  = ^(DIN & din_mask);
    assign bit_end  = TXCLK && (tick_q == 4'd15);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            tick_q       <= 4'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            wls_q        <= 2'd0;
            stb_q        <= 1'b0;
            pen_q        <= 1'b0;
            par_q        <= 1'b0;
            sout_q       <= 1'b1;
            txfinished_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            wls_q        <= wls_d;
            stb_q        <= stb_d;
            pen_q        <= pen_d;
            par_q        <= par_d;
            sout_q       <= sout_d;
            txfinished_q <= txfinished_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        wls_d        = wls_q;
        stb_d        = stb_q;
        pen_d        = pen_q;
        par_d        = par_q;
        txfinished_d = 1'b0;
        level        = 1'b1;
        frame_done   = 1'b0;

        if ((state_q != S_IDLE) && TXCLK) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (TXSTART) begin
                    shift_d = DIN;
                    wls_d   = WLS;
                    stb_d   = STB;
                    pen_d   = PEN;
                    par_d   = SP ? ~EPS : (EPS ? din_xor : ~din_xor);
                    tick_d  = 4'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                level = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                level = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                        bit_d   = 3'd0;
                        state_d = pen_q ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                level = par_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stb_q) begin
                        state_d = S_STOP2;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                // Five-bit words get a half-bit second stop (1.5 stop bits total).
                if (TXCLK && (tick_q == ((wls_q == 2'b00) ? 4'd7 : 4'd15))) begin
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_done) begin
            state_d      = S_IDLE;
            tick_d       = 4'd0;
            txfinished_d = 1'b1;
        end

        if (CLEAR) begin
            state_d      = S_IDLE;
            tick_d       = 4'd0;
            bit_d        = 3'd0;
            txfinished_d = 1'b0;
        end

        sout_d = BC ? 1'b0 : (CLEAR ? 1'b1 : level);
    end

    assign SOUT       = sout_q;
    assign TXFINISHED = txfinished_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a per-TXCLK-pulse waveform model of each frame predicts
// SOUT and TXFINISHED on every clock cycle.
module tb_uart_transmitter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TXCLK;
    logic       TXSTART;
    logic       CLEAR;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic [7:0] DIN;
    logic       TXFINISHED;
    logic       SOUT;

    uart_transmitter dut (
        .CLK        (CLK),
        .RST        (RST),
        .TXCLK      (TXCLK),
        .TXSTART    (TXSTART),
        .CLEAR      (CLEAR),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .BC         (BC),
        .DIN        (DIN),
        .TXFINISHED (TXFINISHED),
        .SOUT       (SOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: line level for every TXCLK pulse of the frame in flight.
    bit m_q[$];
    bit m_active = 1'b0;
    int m_n = 0;
    bit m_level = 1'b1;

    int cyc = 0;
    int tx_div = 4;
    bit tx_stuck = 1'b0;
    int fin_count = 0;
    int fin_cyc = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_frame();
        int nb;
        bit x;
        bit p;
        nb = int'(WLS) + 5;
        x  = 1'b0;
        m_q.delete();
        repeat (16) m_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            x ^= DIN[i];
            repeat (16) m_q.push_back(DIN[i]);
        end
        if (PEN) begin
            p = SP ? !EPS : (EPS ? x : !x);
            repeat (16) m_q.push_back(p);
        end
        repeat (16) m_q.push_back(1'b1);
        if (STB) begin
            repeat ((WLS == 2'b00) ? 8 : 16) m_q.push_back(1'b1);
        end
    endtask

    // One clock cycle: predict from the inputs seen at this edge, then compare.
    task automatic step();
        bit exp_sout;
        bit exp_txf;
        TXCLK   = tx_stuck ? 1'b0 : ((cyc % tx_div) == 0);
        exp_txf = 1'b0;
        if (RST) begin
            m_active = 1'b0;
            m_level  = 1'b1;
            exp_sout = 1'b1;
        end else begin
            exp_sout = BC ? 1'b0 : (CLEAR ? 1'b1 : m_level);
            if (CLEAR) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (TXSTART) begin
                    build_frame();
                    m_active = 1'b1;
                    m_n      = 0;
                end
            end else if (TXCLK) begin
                m_n++;
                if (m_n == m_q.size()) begin
                    m_active = 1'b0;
                    exp_txf  = 1'b1;
                end
            end
            m_level = m_active ? m_q[m_n] : 1'b1;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (TXFINISHED === 1'b1) begin
            fin_count++;
            fin_cyc = cyc;
        end
        check("sout", SOUT, exp_sout);
        check("txfinished", TXFINISHED, exp_txf);
    endtask

    task automatic run_until_idle();
        int k;
        k = 0;
        while (m_active && k < 5000) begin
            step();
            k++;
        end
    endtask

    task automatic set_fmt(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic st, input logic [7:0] d);
        WLS = w; STB = s; PEN = p; EPS = e; SP = st; DIN = d;
    endtask

    task automatic send_frame(input string tag);
        fin_count = 0;
        TXSTART = 1'b1;
        step();
        TXSTART = 1'b0;
        run_until_idle();
        repeat (3) step();
        check_int({tag, "_finished_count"}, fin_count, 1);
    endtask

    initial begin
        int start_cyc;
        RST = 1'b1; TXSTART = 1'b0; CLEAR = 1'b0; BC = 1'b0; TXCLK = 1'b0;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) step();
        RST = 1'b0;
        repeat (4) step();

        // 8N1 0x55 with TXCLK every 4 CLK; frame must take exactly 640 CLK.
        tx_div = 4;
        while ((cyc % 4) != 0) step();
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        fin_count = 0;
        TXSTART = 1'b1;
        step();
        TXSTART = 1'b0;
        start_cyc = cyc;
        run_until_idle();
        repeat (3) step();
        check_int("8n1_finished_count", fin_count, 1);
        check_int("8n1_frame_cycles", fin_cyc - start_cyc, 640);

        // 7E1 / 7O1 with 0x83, then 5N1.5 and 8N2, then stick parity.
        tx_div = 2;
        set_fmt(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h83); send_frame("7e1");
        set_fmt(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h83); send_frame("7o1");
        set_fmt(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F); send_frame("5n15");
        set_fmt(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA6); send_frame("8n2");
        set_fmt(2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF); send_frame("stick_e1");
        set_fmt(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF); send_frame("stick_e0");

        // Break mid-data, then release; frame timing must be unchanged.
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
        fin_count = 0;
        TXSTART = 1'b1; step(); TXSTART = 1'b0;
        repeat (100) step();
        BC = 1'b1;
        repeat (40) step();
        BC = 1'b0;
        run_until_idle();
        repeat (2) step();
        check_int("break_finished_count", fin_count, 1);

        // Abort during data bit 3, then a clean frame.
        set_fmt(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC9);
        fin_count = 0;
        TXSTART = 1'b1; step(); TXSTART = 1'b0;
        repeat (2 * (64 + 8)) step();
        CLEAR = 1'b1; TXSTART = 1'b1;
        step();
        CLEAR = 1'b0; TXSTART = 1'b0;
        repeat (20) step();
        check_int("clear_finished_count", fin_count, 0);
        set_fmt(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2D); send_frame("after_clear");

        // Baud enable stuck low mid-frame freezes everything.
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96);
        fin_count = 0;
        TXSTART = 1'b1; step(); TXSTART = 1'b0;
        repeat (90) step();
        tx_stuck = 1'b1;
        repeat (60) step();
        tx_stuck = 1'b0;
        run_until_idle();
        repeat (2) step();
        check_int("stuck_finished_count", fin_count, 1);

        // Asynchronous reset mid-frame acts without a clock edge.
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        TXSTART = 1'b1; step(); TXSTART = 1'b0;
        repeat (50) step();
        #3;
        RST = 1'b1;
        #1;
        check("async_rst_sout", SOUT, 1'b1);
        check("async_rst_txfinished", TXFINISHED, 1'b0);
        repeat (2) step();
        RST = 1'b0;
        repeat (3) step();

        // Back-to-back frames with TXSTART held high.
        set_fmt(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        TXSTART = 1'b1;
        for (int f = 0; f < 3; f++) begin
            DIN = 8'($urandom);
            fin_count = 0;
            step();
            run_until_idle();
            check_int("b2b_finished_count", fin_count, 1);
        end
        TXSTART = 1'b0;
        repeat (3) step();

        // Random formats and data; inputs are scrambled mid-frame to prove latching.
        for (int f = 0; f < 12; f++) begin
            tx_div = 1 + int'($urandom_range(2));
            set_fmt(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 8'($urandom));
            fin_count = 0;
            TXSTART = 1'b1; step(); TXSTART = 1'b0;
            repeat (5) step();
            set_fmt(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 8'($urandom));
            run_until_idle();
            repeat (int'($urandom_range(3))) step();
            check_int("random_finished_count", fin_count, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
